mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Round-robin arbiter sharing one 16x32 single-port memory (enable / read_write / address / data_in in; data_out / valid_out out, 1-cycle registered read) among NREQ requesters.
- Accepts one command at a time, sequences the memory access, and returns a per-requester response pulse carrying read data or a write acknowledge.
- A watchdog flags reads whose valid_out never arrives.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ADDR_W, 4, memory address width.
- DATA_W, 32, memory data width.
- MAX_WAIT, 4, cycles WAIT_RD tolerates without mem_valid_out before error.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester command valid; held with fields stable until req_ready.
- req_rw  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  packed write data.
- req_ready  out  NREQ  one-hot accept pulse, 1 cycle.
- rsp_valid  out  NREQ  one-hot response pulse, 1 cycle.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid; 0 for writes and errors.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- mem_enable  out  1  to memory enable.
- mem_read_write  out  1  to memory read_write (1 = write).
- mem_address  out  ADDR_W  to memory address.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_data_out  in  DATA_W  from memory data_out.
- mem_valid_out  in  1  from memory valid_out.

Behaviour:
- **Reset (rst = 1 at an edge):**
  - state = IDLE, rr pointer = 0, watchdog = 0, latched command cleared.
  - All outputs 0.
  - Reset mid-transaction abandons it: no rsp_valid is issued. Memory reset is handled outside this block.
- **FSM states:** IDLE, ISSUE, WAIT_RD, RESP.
- **IDLE:**
  - If any req_valid is high, pick winner w by round-robin: first set bit at or after the pointer, wrapping.
  - req_ready[w] = 1 combinationally in that same cycle.
  - Latch rw, addr, wdata and w; go to ISSUE.
  - Pointer becomes (w+1) mod NREQ.
  - No req_valid: stay in IDLE, req_ready = 0.
- **ISSUE:**
  - mem_enable = 1; mem_read_write / address / data_in from latched command.
  - Exactly one enable cycle per command.
  - Write goes to RESP; read goes to WAIT_RD with watchdog = 0.
- **WAIT_RD:**
  - mem_enable = 0.
  - If mem_valid_out = 1: capture mem_data_out, err = 0, go to RESP. The nominal case is the first WAIT_RD cycle.
  - Otherwise increment the watchdog. On reaching MAX_WAIT: err = 1, data = 0, go to RESP.
- **RESP:**
  - rsp_valid[w] = 1, rsp_rdata and rsp_err driven from registers; go to IDLE.
  - For writes, rsp_rdata = 0 and rsp_err = 0.
- **Latency:**
  - Read: accept at T, enable at T+1, capture at T+2, rsp_valid at T+3. Next accept is possible at T+4.
  - Write: accept at T, enable at T+1, rsp_valid at T+2. Next accept at T+3.
- **Outside ISSUE:** mem_enable = 0 and mem_read_write / address / data_in = 0.
- **Outside RESP:** rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- **Request rules:**
  - req_valid arriving in non-IDLE states waits; no request is dropped.
  - A requester dropping req_valid before req_ready is legal: it is simply not considered.
  - Simultaneous requests: exactly one req_ready bit per accept.
  - A requester winning with pointer at NREQ-1 wraps the pointer to 0.
- **Fairness:** a continuously requesting requester waits at most NREQ-1 transactions.

Decomposition:
- **Package mem_arb_pkg:**
  - State enum (IDLE, ISSUE, WAIT_RD, RESP).
  - ADDR_W / DATA_W defaults.
  - Watchdog counter width: $clog2(MAX_WAIT+1).
  - RW_WRITE = 1 / RW_READ = 0 constants.
- **Sub-module mem_rr_picker:** combinational. Inputs req vector and pointer; outputs one-hot grant and index. Reused by future requester-sharing blocks.

Test Plan:
- Reset: hold rst high 3 cycles with req_valid = 2'b11 -> all outputs 0 and no req_ready. After release, first grant goes to requester 0.
- Write then read: req0 writes addr 4'h3 data 32'hDEADBEEF.
  - Expect req_ready[0] at T, mem_enable = 1 / rw = 1 at T+1, rsp_valid[0] at T+2 with rsp_rdata = 0.
  - Then req0 reads addr 4'h3 -> rsp_valid[0] 3 cycles after accept, rsp_rdata = 32'hDEADBEEF, rsp_err = 0.
- Contention: both requesters continuously issue reads.
  - Grants alternate 0, 1, 0, 1.
  - Each read response arrives 3 cycles after its accept.
  - Accepts are spaced 4 cycles apart.
- Timeout: memory model holds mem_valid_out = 0 on a read from req1 -> rsp_valid[1] with rsp_err = 1 and rsp_rdata = 0, after MAX_WAIT = 4 WAIT_RD cycles. The next request then proceeds normally.
- Reset mid-read: assert rst during WAIT_RD -> no rsp_valid. State returns to IDLE and pointer to 0; the next request completes correctly.
- Late arrival: req1 asserts while the req0 write is in ISSUE -> req1 is accepted in the first IDLE cycle after req0's RESP, and is not lost.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_WAIT_DEF = 4;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ = 1'b0;
  function automatic int wd_width(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction
endpackage

// File: rtl/mem_rr_picker.sv
// mem_rr_picker: round-robin pick of the first request at or after ptr, wrapping
module mem_rr_picker #(
  parameter int NREQ = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W:0] s;
  logic [IDX_W-1:0] j;
  // scan from the farthest offset down so the nearest request wins last
  always_comb begin
    grant = '0;
    idx = '0;
    s = '0;
    j = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + (IDX_W + 1)'(i);
      j = s >= (IDX_W + 1)'(NREQ) ? IDX_W'(s - (IDX_W + 1)'(NREQ)) : IDX_W'(s);
      if (req[j]) begin
        grant = NREQ'(1) << j;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one registered-read memory among NREQ requesters
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_rw,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     mem_enable,
  output logic                     mem_read_write,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [DATA_W-1:0]        mem_data_in,
  input  logic [DATA_W-1:0]        mem_data_out,
  input  logic                     mem_valid_out
);
  localparam int IDX_W = $clog2(NREQ);
  localparam int WD_W = wd_width(MAX_WAIT);
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, gidx, w_q;
  logic [NREQ-1:0] grant;
  logic [WD_W-1:0] wd, wd_inc;
  logic rw_q, err_q, accept, timeout, issue, resp;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  mem_rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req(req_valid), .ptr(ptr), .grant(grant), .idx(gidx)
  );
  assign accept = state == IDLE && |req_valid;
  assign issue = state == ISSUE;
  assign resp = state == RESP;
  assign wd_inc = wd + 1'b1;
  assign timeout = wd_inc == WD_W'(MAX_WAIT);
  // grant is suppressed while reset is held so nothing is accepted and then abandoned
  assign req_ready = (accept && !rst) ? grant : '0;
  assign mem_enable = issue;
  assign mem_read_write = issue && rw_q == RW_WRITE;
  assign mem_address = issue ? addr_q : '0;
  assign mem_data_in = issue ? wdata_q : '0;
  assign rsp_valid = resp ? NREQ'(1) << w_q : '0;
  assign rsp_rdata = resp ? rdata_q : '0;
  assign rsp_err = resp && err_q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? ISSUE : IDLE;
      ISSUE:   state_n = rw_q == RW_READ ? WAIT_RD : RESP;
      WAIT_RD: state_n = (mem_valid_out || timeout) ? RESP : WAIT_RD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      wd <= '0;
      w_q <= '0;
      rw_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        rw_q <= req_rw[gidx];
        addr_q <= req_addr[gidx*ADDR_W +: ADDR_W];
        wdata_q <= req_wdata[gidx*DATA_W +: DATA_W];
        w_q <= gidx;
        ptr <= gidx == IDX_W'(NREQ - 1) ? '0 : gidx + 1'b1;
      end
      if (issue) begin
        wd <= '0;
        rdata_q <= '0;
        err_q <= 1'b0;
      end
      if (state == WAIT_RD) begin
        if (mem_valid_out) rdata_q <= mem_data_out;
        else begin
          wd <= wd_inc;
          err_q <= timeout;
        end
      end
    end
  end
endmodule
